uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Packet-level round-robin arbiter that shares the single UART byte transmitter on the 50 MHz `w_clk50m` domain between several message sources: the phase/frequency report generator, a status/alarm reporter and a command-response source. Each source streams bytes with valid/ready/last. The arbiter grants one source per packet, sequences the transmitter's start/busy handshake byte by byte, and revokes a grant from a source that stalls mid-packet.

## Interface
- `N_SRC`, default 3: number of sources; index 0 is the report generator.
- `TIMEOUT`, default 50000: mid-packet stall limit in clocks (1 ms at 50 MHz), ≥ 2.
- `i_clk`, in, 1: 50 MHz system clock.
- `i_res_n`, in, 1: reset; asynchronous, active-low.
- `i_src_valid`, in, `N_SRC`: source has a byte.
- `i_src_data`, in, 8*`N_SRC`: byte of source k on bits [8k+7:8k].
- `i_src_last`, in, `N_SRC`: byte is the final byte of the packet.
- `o_src_ready`, out, `N_SRC`: byte accepted when ready & valid.
- `o_tx_start`, out, 1: one-cycle start pulse to the UART byte transmitter.
- `o_tx_data`, out, 8: byte to send; stable from the start pulse until busy falls.
- `i_tx_busy`, in, 1: transmitter busy; rises the cycle after `o_tx_start`.
- `o_grant`, out, `N_SRC`: one-hot current owner; all zero when idle.
- `o_timeout`, out, 1: one-cycle pulse when a grant is revoked.
- `o_timeout_cnt`, out, 8: saturating count of revocations.

## Operation
- States: IDLE, SEND, START, BUSY.
- IDLE: if any `i_src_valid` is high, latch the round-robin winner into `o_grant`, searching upward from pointer `ptr` and wrapping. Go to SEND. If none is valid, stay in IDLE.
- SEND: `o_src_ready` = `o_grant`. When the granted source is valid, the byte is accepted: latch data into `o_tx_data`, latch last, clear the stall counter, and go to START. Valid on ungranted sources is ignored; their ready stays 0.
- START: `o_tx_start` = 1 for exactly one cycle, then go to BUSY.
- BUSY: the first BUSY cycle is a mandatory dwell. From the second cycle on, exit when `i_tx_busy` = 0:
  - if last was set, clear `o_grant`, set `ptr` to (granted index + 1) mod `N_SRC`, and go to IDLE;
  - otherwise go to SEND.
- Stall: in SEND, the stall counter increments every cycle the granted valid is low. When it reaches `TIMEOUT`-1:
  - pulse `o_timeout`;
  - increment `o_timeout_cnt`, saturating at 255;
  - clear `o_grant` and set `ptr` to the next index;
  - go to IDLE. The partially sent packet is abandoned.
- A source must not drop valid mid-packet except by stalling. A source whose grant was revoked restarts its packet at its own discretion.

## Timing
- Reset (asynchronous): state IDLE, `ptr` 0, and every output 0 (`o_src_ready`, `o_tx_start`, `o_tx_data`, `o_grant`, `o_timeout`, `o_timeout_cnt`). The stall counter is also cleared. Reset mid-byte abandons the byte; the transmitter shares the same reset.
- Latency from valid in IDLE (cycle 0):
  - `o_grant` set at cycle 1;
  - accept at cycle 1 if valid is still high;
  - `o_tx_start` at cycle 2.
- Byte-to-byte within a packet: next accept occurs 1 cycle after busy falls, and the next start 1 cycle after that.
- Packet turnaround: IDLE re-arbitration occurs 1 cycle after busy falls on the last byte.
- Simultaneous requests: the lowest index ≥ `ptr` wins, with wrap-around. Example: `ptr`=2, `N_SRC`=3, valid=3'b011 → source 0 wins.
- Fairness: a source that keeps requesting waits at most `N_SRC`-1 packets.
- Width rules: the stall counter is clog2(`TIMEOUT`) bits. `o_timeout_cnt` does not wrap.
- Both state and the ready outputs are registered with the state; `o_src_ready` is a decode of the registered state and grant.

## Structure
- Shared package: state encoding localparams (IDLE/SEND/START/BUSY), the default `TIMEOUT`, and the 8-bit byte width constant.
- One sub-module, `rr_pick`: a combinational one-hot round-robin picker. Inputs are the request vector and `ptr`; outputs are the one-hot winner and an any-request flag.
- FSM, counters and data latch live in `uart_tx_arb`.

## Test plan
- Single source 0 sends a 3-byte packet 0x41, 0x42, 0x0A (last on 0x0A), with the busy model high for 10 cycles per byte → exactly 3 start pulses with data in order; `o_grant`=001 throughout; `ptr`=1 afterwards.
- All three sources request continuously with 2-byte packets → grant order 0, 1, 2, 0, and no bytes are interleaved between packets.
- Source 1 is granted, sends 1 byte, then drops valid with `TIMEOUT`=20 → `o_timeout` pulses 19 cycles after SEND entry; `o_timeout_cnt`=1; grant clears; source 2 is served next.
- 300 forced timeouts → `o_timeout_cnt` holds at 255.
- Assert `i_res_n` low during BUSY of byte 2 → all outputs 0 asynchronously. After release with valid high, the first start pulse comes 2 cycles later from source 0.
- Valid on source 2 during source 0's packet → `o_src_ready`[2] stays 0 until source 0's last byte completes.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
package uart_tx_arb_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEFAULT_TIMEOUT = 50000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        START = 2'd2,
        BUSY  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational one-hot round-robin picker: lowest requesting index at or
// above ptr wins, wrapping past the top.
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic             any
);

    int               sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            sum = int'(ptr) + i;
            if (sum >= N) sum = sum - N;
            idx = PTR_W'(sum);
            if (req[idx] && !found) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one UART byte transmitter between
// N_SRC valid/ready/last byte streams, with mid-packet stall revocation.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N_SRC   = 3,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    i_clk,
    input  logic                    i_res_n,
    input  logic [N_SRC-1:0]        i_src_valid,
    input  logic [BYTE_W*N_SRC-1:0] i_src_data,
    input  logic [N_SRC-1:0]        i_src_last,
    output logic [N_SRC-1:0]        o_src_ready,
    output logic                    o_tx_start,
    output logic [BYTE_W-1:0]       o_tx_data,
    input  logic                    i_tx_busy,
    output logic [N_SRC-1:0]        o_grant,
    output logic                    o_timeout,
    output logic [7:0]              o_timeout_cnt
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 2);

    state_t             state, state_next;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [CNT_W-1:0]   stall_cnt;
    logic               last_q;
    logic               dwell;
    logic [N_SRC-1:0]   pick;
    logic               any_req;
    logic               sel_valid;
    logic               sel_last;
    logic [BYTE_W-1:0]  sel_data;
    logic               do_grant;
    logic               do_accept;
    logic               do_release;
    logic               do_timeout;

    rr_pick #(.N(N_SRC), .PTR_W(PTR_W)) u_pick (
        .req  (i_src_valid),
        .ptr  (ptr),
        .pick (pick),
        .any  (any_req)
    );

    // One-hot grant selects the owner's stream and yields its index.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        grant_idx = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (o_grant[k]) begin
                sel_valid = i_src_valid[k];
                sel_last  = i_src_last[k];
                sel_data  = i_src_data[BYTE_W*k +: BYTE_W];
                grant_idx = PTR_W'(k);
            end
        end
    end

    assign next_ptr    = (grant_idx == PTR_W'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
    assign o_src_ready = (state == SEND) ? o_grant : '0;
    assign o_tx_start  = (state == START);

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_accept  = 1'b0;
        do_release = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = SEND;
                    do_grant   = 1'b1;
                end
            end
            SEND: begin
                if (sel_valid) begin
                    state_next = START;
                    do_accept  = 1'b1;
                end else if (stall_cnt == STALL_LAST) begin
                    state_next = IDLE;
                    do_timeout = 1'b1;
                end
            end
            START: state_next = BUSY;
            BUSY: begin
                // The first BUSY cycle is a dwell while the transmitter raises busy.
                if (!dwell && !i_tx_busy) begin
                    if (last_q) begin
                        state_next = IDLE;
                        do_release = 1'b1;
                    end else begin
                        state_next = SEND;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            ptr           <= '0;
            o_grant       <= '0;
            o_tx_data     <= '0;
            last_q        <= 1'b0;
            stall_cnt     <= '0;
            dwell         <= 1'b0;
            o_timeout     <= 1'b0;
            o_timeout_cnt <= '0;
        end else begin
            o_timeout <= do_timeout;
            dwell     <= (state == START);
            if (do_grant) begin
                o_grant   <= pick;
                stall_cnt <= '0;
            end
            if (do_accept) begin
                o_tx_data <= sel_data;
                last_q    <= sel_last;
                stall_cnt <= '0;
            end else if (state == SEND) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (do_release || do_timeout) begin
                o_grant <= '0;
                ptr     <= next_ptr;
            end
            if (do_timeout && (o_timeout_cnt != 8'hFF)) begin
                o_timeout_cnt <= o_timeout_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: three queued byte sources, a 10-cycle busy
// transmitter model and a start-pulse log checked against hand-written tables.
module tb_uart_tx_arb;

    localparam int N        = 3;
    localparam int TMO      = 20;
    localparam int BUSY_LEN = 10;

    logic           clk = 1'b0;
    logic           res_n = 1'b0;
    logic [N-1:0]   src_valid;
    logic [8*N-1:0] src_data;
    logic [N-1:0]   src_last;
    logic [N-1:0]   src_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [N-1:0]   grant;
    logic           timeout;
    logic [7:0]     timeout_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_left;

    logic [8:0]   q0[$];
    logic [8:0]   q1[$];
    logic [8:0]   q2[$];
    logic [7:0]   log_data[$];
    logic [N-1:0] log_grant[$];
    int           log_cyc[$];

    uart_tx_arb #(.N_SRC(N), .TIMEOUT(TMO)) dut (
        .i_clk         (clk),
        .i_res_n       (res_n),
        .i_src_valid   (src_valid),
        .i_src_data    (src_data),
        .i_src_last    (src_last),
        .o_src_ready   (src_ready),
        .o_tx_start    (tx_start),
        .o_tx_data     (tx_data),
        .i_tx_busy     (tx_busy),
        .o_grant       (grant),
        .o_timeout     (timeout),
        .o_timeout_cnt (timeout_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy high for BUSY_LEN cycles starting the cycle after start.
    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            tx_busy   <= 1'b0;
            busy_left <= 0;
        end else if (tx_start) begin
            tx_busy   <= 1'b1;
            busy_left <= BUSY_LEN - 1;
        end else if (tx_busy) begin
            if (busy_left == 0) tx_busy <= 1'b0;
            else                busy_left <= busy_left - 1;
        end
    end

    always @(negedge clk) begin
        if (tx_start) begin
            log_data.push_back(tx_data);
            log_grant.push_back(grant);
            log_cyc.push_back(cyc);
        end
    end

    // Source model: each queue presents its head byte; a byte leaves after the edge that accepts it.
    initial begin : src_driver
        logic [N-1:0] acc;
        src_valid = '0;
        src_data  = '0;
        src_last  = '0;
        forever begin
            @(negedge clk);
            acc = src_valid & src_ready;
            @(posedge clk);
            #1;
            if (acc[0] && q0.size() > 0) void'(q0.pop_front());
            if (acc[1] && q1.size() > 0) void'(q1.pop_front());
            if (acc[2] && q2.size() > 0) void'(q2.pop_front());
            src_valid[0]     = (q0.size() > 0);
            src_data[7:0]    = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
            src_last[0]      = (q0.size() > 0) ? q0[0][8] : 1'b0;
            src_valid[1]     = (q1.size() > 0);
            src_data[15:8]   = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
            src_last[1]      = (q1.size() > 0) ? q1[0][8] : 1'b0;
            src_valid[2]     = (q2.size() > 0);
            src_data[23:16]  = (q2.size() > 0) ? q2[0][7:0] : 8'h00;
            src_last[2]      = (q2.size() > 0) ? q2[0][8] : 1'b0;
        end
    end

    initial begin : watchdog
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic push_byte(input int k, input logic [7:0] d, input logic l);
        case (k)
            0:       q0.push_back({l, d});
            1:       q1.push_back({l, d});
            default: q2.push_back({l, d});
        endcase
    endtask

    task automatic clear_log();
        log_data.delete();
        log_grant.delete();
        log_cyc.delete();
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (log_data.size() >= n) break;
            @(negedge clk);
            #1;
        end
        ok = (log_data.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (grant == '0) break;
            @(negedge clk);
        end
        ok = (grant == '0);
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (grant !== 3'b000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 000", grant); end
        checks++;
        if (src_ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 000", src_ready); end
        checks++;
        if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start: got %b expected 0", tx_start); end
        checks++;
        if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", tx_data); end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout); end
        checks++;
        if (timeout_cnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_timeout_cnt: got %0d expected 0", timeout_cnt); end
        res_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (grant !== 3'b000) begin errors++; $display("[TB] FAIL idle_no_request: got grant %b expected 000", grant); end
    endtask

    task automatic test_round_robin();
        logic [7:0]   exp_d [12] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31,
                                     8'h12, 8'h13, 8'h22, 8'h23, 8'h32, 8'h33};
        logic [N-1:0] exp_g [12] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100,
                                     3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
        int           gap;
        bit           ok;
        clear_log();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                push_byte(k, 8'(16 * (k + 1) + 2 * p), 1'b0);
                push_byte(k, 8'(16 * (k + 1) + 2 * p + 1), 1'b1);
            end
        end
        wait_starts(12, 800, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL rr_start_count: got %0d expected 12", log_data.size()); end
        wait_idle(100, ok);
        for (int i = 0; i < 12 && i < log_data.size(); i++) begin
            checks++;
            if (log_data[i] !== exp_d[i] || log_grant[i] !== exp_g[i]) begin
                errors++;
                $display("[TB] FAIL rr_byte%0d: got data %h grant %b expected data %h grant %b",
                         i, log_data[i], log_grant[i], exp_d[i], exp_g[i]);
            end
        end
        for (int i = 1; i < 12 && i < log_cyc.size(); i++) begin
            gap = log_cyc[i] - log_cyc[i-1];
            checks++;
            if (gap != ((i % 2 == 0) ? 14 : 13)) begin
                errors++;
                $display("[TB] FAIL rr_gap%0d: got %0d cycles expected %0d", i, gap, (i % 2 == 0) ? 14 : 13);
            end
        end
    endtask

    task automatic test_single_packet();
        logic [7:0] exp_d [3] = '{8'h41, 8'h42, 8'h0A};
        bit         bad_grant;
        bit         ok;
        clear_log();
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b0);
        push_byte(0, 8'h0A, 1'b1);
        @(negedge clk);
        checks++;
        if (grant !== 3'b000) begin errors++; $display("[TB] FAIL single_cycle0_grant: got %b expected 000", grant); end
        @(negedge clk);
        checks++;
        if (grant !== 3'b001 || src_ready !== 3'b001) begin
            errors++;
            $display("[TB] FAIL single_cycle1: got grant %b ready %b expected 001 001", grant, src_ready);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
            errors++;
            $display("[TB] FAIL single_cycle2_start: got start %b data %h expected 1 41", tx_start, tx_data);
        end
        bad_grant = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (grant == 3'b000) break;
            if (grant !== 3'b001) bad_grant = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad_grant || grant !== 3'b000) begin
            errors++;
            $display("[TB] FAIL single_grant_hold: got stray %b final %b expected 001 then 000", bad_grant, grant);
        end
        wait_starts(3, 10, ok);
        checks++;
        if (log_data.size() != 3) begin errors++; $display("[TB] FAIL single_start_count: got %0d expected 3", log_data.size()); end
        for (int i = 0; i < 3 && i < log_data.size(); i++) begin
            checks++;
            if (log_data[i] !== exp_d[i]) begin
                errors++;
                $display("[TB] FAIL single_byte%0d: got %h expected %h", i, log_data[i], exp_d[i]);
            end
        end
        if (log_cyc.size() >= 3) begin
            checks++;
            if (log_cyc[1] - log_cyc[0] != 13 || log_cyc[2] - log_cyc[1] != 13) begin
                errors++;
                $display("[TB] FAIL single_byte_gap: got %0d %0d expected 13 13",
                         log_cyc[1] - log_cyc[0], log_cyc[2] - log_cyc[1]);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        clear_log();
        push_byte(0, 8'hA0, 1'b1);
        push_byte(1, 8'hB1, 1'b1);
        wait_starts(2, 200, ok);
        wait_idle(100, ok);
        checks++;
        if (log_grant.size() < 2 || log_grant[0] !== 3'b010 || log_data[0] !== 8'hB1 || log_grant[1] !== 3'b001) begin
            errors++;
            $display("[TB] FAIL sim_ptr1_order: got %0d starts first grant %b data %h expected 010 B1 then 001",
                     log_grant.size(), (log_grant.size() > 0) ? log_grant[0] : 3'b000,
                     (log_data.size() > 0) ? log_data[0] : 8'h00);
        end
        clear_log();
        push_byte(1, 8'hC1, 1'b1);
        wait_starts(1, 200, ok);
        wait_idle(100, ok);
        clear_log();
        push_byte(0, 8'hD0, 1'b1);
        push_byte(1, 8'hE1, 1'b1);
        wait_starts(2, 200, ok);
        wait_idle(100, ok);
        checks++;
        if (log_grant.size() < 2 || log_grant[0] !== 3'b001 || log_data[0] !== 8'hD0 || log_grant[1] !== 3'b010) begin
            errors++;
            $display("[TB] FAIL sim_ptr2_wrap: got %0d starts first grant %b data %h expected 001 D0 then 010",
                     log_grant.size(), (log_grant.size() > 0) ? log_grant[0] : 3'b000,
                     (log_data.size() > 0) ? log_data[0] : 8'h00);
        end
    endtask

    task automatic test_ungranted_ignored();
        bit ok;
        bit leak;
        clear_log();
        push_byte(0, 8'h51, 1'b0);
        push_byte(0, 8'h52, 1'b0);
        push_byte(0, 8'h53, 1'b1);
        repeat (2) @(negedge clk);
        push_byte(2, 8'h61, 1'b1);
        leak = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (grant !== 3'b001) break;
            if (src_ready[2] !== 1'b0) leak = 1'b1;
        end
        checks++;
        if (leak) begin errors++; $display("[TB] FAIL ungranted_ready: got ready[2]=1 during src0 packet expected 0"); end
        wait_starts(4, 200, ok);
        wait_idle(100, ok);
        checks++;
        if (log_grant.size() < 4 || log_grant[2] !== 3'b001 || log_grant[3] !== 3'b100 || log_data[3] !== 8'h61) begin
            errors++;
            $display("[TB] FAIL ungranted_next: got %0d starts expected src0 x3 then src2 byte 61", log_grant.size());
        end
    endtask

    task automatic test_timeout();
        int phase;
        bit early;
        bit ok;
        clear_log();
        push_byte(1, 8'h77, 1'b0);
        push_byte(2, 8'h88, 1'b1);
        phase = 0;
        for (int i = 0; i < 200 && phase < 3; i++) begin
            @(negedge clk);
            if (phase == 0 && src_ready[1]) phase = 1;
            else if (phase == 1 && !src_ready[1]) phase = 2;
            else if (phase == 2 && src_ready[1]) phase = 3;
        end
        checks++;
        if (phase != 3) begin errors++; $display("[TB] FAIL timeout_send_entry: got phase %0d expected 3", phase); end
        early = 1'b0;
        repeat (18) begin
            @(negedge clk);
            if (timeout) early = 1'b1;
        end
        checks++;
        if (early) begin errors++; $display("[TB] FAIL timeout_early: got pulse before cycle 19 expected none"); end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b1 || timeout_cnt !== 8'd1 || grant !== 3'b000) begin
            errors++;
            $display("[TB] FAIL timeout_cycle19: got pulse %b cnt %0d grant %b expected 1 1 000", timeout, timeout_cnt, grant);
        end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0 || grant !== 3'b100) begin
            errors++;
            $display("[TB] FAIL timeout_after: got pulse %b grant %b expected 0 100", timeout, grant);
        end
        wait_starts(2, 200, ok);
        wait_idle(100, ok);
        checks++;
        if (log_data.size() < 2 || log_data[1] !== 8'h88) begin
            errors++;
            $display("[TB] FAIL timeout_src2_served: got %0d starts expected src2 byte 88", log_data.size());
        end
    endtask

    task automatic test_saturate();
        int seen_total;
        bit seen;
        seen_total = 0;
        for (int i = 0; i < 300; i++) begin
            push_byte(0, 8'h99, 1'b0);
            seen = 1'b0;
            for (int j = 0; j < 200; j++) begin
                @(negedge clk);
                if (timeout) begin seen = 1'b1; break; end
            end
            if (!seen) break;
            seen_total++;
            if (seen_total == 253) begin
                checks++;
                if (timeout_cnt !== 8'd254) begin errors++; $display("[TB] FAIL sat_cnt_254: got %0d expected 254", timeout_cnt); end
            end
        end
        checks++;
        if (seen_total != 300) begin errors++; $display("[TB] FAIL sat_pulses: got %0d expected 300", seen_total); end
        repeat (2) @(negedge clk);
        checks++;
        if (timeout_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_cnt_255: got %0d expected 255", timeout_cnt); end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        clear_log();
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b0);
        push_byte(0, 8'h33, 1'b1);
        wait_starts(2, 200, ok);
        repeat (3) @(negedge clk);
        res_n = 1'b0;
        #1;
        checks++;
        if (grant !== 3'b000 || src_ready !== 3'b000 || tx_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_ctrl: got grant %b ready %b start %b expected 000 000 0", grant, src_ready, tx_start);
        end
        checks++;
        if (tx_data !== 8'h00 || timeout !== 1'b0 || timeout_cnt !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rst_mid_data: got data %h pulse %b cnt %0d expected 00 0 0", tx_data, timeout, timeout_cnt);
        end
        q0.delete();
        q1.delete();
        q2.delete();
        push_byte(0, 8'h55, 1'b1);
        clear_log();
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0 || grant !== 3'b001) begin
            errors++;
            $display("[TB] FAIL rst_release_cycle1: got start %b grant %b expected 0 001", tx_start, grant);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h55 || grant !== 3'b001) begin
            errors++;
            $display("[TB] FAIL rst_release_cycle2: got start %b data %h grant %b expected 1 55 001", tx_start, tx_data, grant);
        end
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL rst_release_idle: got grant %b expected 000", grant); end
    endtask

    initial begin
        $display("[TB] uart_tx_arb bench start");
        test_reset();
        test_round_robin();
        test_single_packet();
        test_simultaneous();
        test_ungranted_ignored();
        test_timeout();
        test_saturate();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
